// File: rtl/dmem_bw_pkg.sv
// dmem_bw_pkg: opcode constants, FSM state type and opcode class helpers
// shared by the data-memory stage and its byte lane.
package dmem_bw_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: big-endian sub-word load extraction, store merge and
// alignment check for one 32-bit memory word.
module dmem_lane
    import dmem_bw_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    logic [31:0] w_hmask;

    // Byte 0 of a word is its most significant byte.
    assign w_byte = i_addr == 2'd0 ? i_word[31:24] :
                    i_addr == 2'd1 ? i_word[23:16] :
                    i_addr == 2'd2 ? i_word[15:8]  : i_word[7:0];
    assign w_half = i_addr[1] ? i_word[15:0] : i_word[31:16];

    assign o_rdata = i_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} :
                     i_op == OP_LBU ? {24'h0, w_byte} :
                     i_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
                     i_op == OP_LHU ? {16'h0, w_half} : i_word;

    assign w_bmask = 32'hFF00_0000 >> {i_addr, 3'b000};
    assign w_hmask = i_addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;

    assign o_merged = i_op == OP_SB ? (i_word & ~w_bmask) | ({4{i_wdata[7:0]}} & w_bmask) :
                      i_op == OP_SH ? (i_word & ~w_hmask) | ({2{i_wdata[15:0]}} & w_hmask) :
                      i_wdata;

    assign o_misaligned = ((i_op == OP_LW || i_op == OP_SW) && i_addr != 2'd0) ||
                          ((i_op == OP_LH || i_op == OP_LHU || i_op == OP_SH) && i_addr[0]);

endmodule

// File: rtl/dmem_bw.sv
// dmem_bw: data-memory stage with sub-word access, alignment/range faults,
// a programmable wait-state stall FSM and the link/ALU writeback mux.
module dmem_bw
    import dmem_bw_pkg::*;
#(
    parameter int DMEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES  = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic        Valid,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    input  logic [31:0] nextPC,
    output logic [31:0] Wdata,
    output logic        Stall,
    output logic        Fault
);

    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic [31:0]   r_mem [DMEM_DEPTH];
    state_t        r_state;
    logic [3:0]    r_cnt;

    state_t        w_nstate;
    logic [3:0]    w_ncnt;
    logic          w_stall;
    logic          w_done;
    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_rdata;
    logic [31:0]   w_merged;
    logic          w_mis;
    logic          w_oor;
    logic          w_mem;
    logic          w_ok;
    logic          w_we;
    logic          w_link;
    logic          w_unused;

    assign w_op     = Ins[31:26];
    assign w_funct  = Ins[5:0];
    assign w_unused = ^Ins[25:6];
    assign w_idx    = Result[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_oor    = (Result >> (AW + 2)) != 32'd0;

    dmem_lane u_lane (
        .i_word      (w_word),
        .i_wdata     (Rdata2),
        .i_op        (w_op),
        .i_addr      (Result[1:0]),
        .o_rdata     (w_rdata),
        .o_merged    (w_merged),
        .o_misaligned(w_mis)
    );

    assign w_mem = Valid && is_mem(w_op);
    assign Fault = RST && w_mem && (w_mis || w_oor);
    assign w_ok  = w_mem && !Fault;

    // Dropping Valid (or the op turning into a fault) while waiting aborts.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_stall  = 1'b0;
        w_done   = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_ok && WAIT_CYCLES > 0) begin
                w_stall  = 1'b1;
                w_ncnt   = CNT_INIT;
                w_nstate = S_WAIT;
            end else begin
                w_done = w_ok;
            end
        end else if (!w_ok) begin
            w_nstate = S_IDLE;
            w_ncnt   = 4'd0;
        end else if (r_cnt != 4'd0) begin
            w_stall = 1'b1;
            w_ncnt  = r_cnt - 4'd1;
        end else begin
            w_done   = 1'b1;
            w_nstate = S_IDLE;
        end
    end

    assign Stall = RST && w_stall;
    assign w_we  = RST && w_done && is_store(w_op);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (CLEAR_ON_RST != 0)
                for (int i = 0; i < DMEM_DEPTH; i++)
                    r_mem[i] <= 32'd0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign w_link = w_op == OP_JAL || (w_op == OP_RTYPE && w_funct == FN_JALR);
    assign Wdata  = (w_mem && is_load(w_op)) ? (Fault ? 32'd0 : w_rdata) :
                    w_link ? nextPC : Result;

endmodule
